// File: rtl/game_ctrl.sv
// Game-state controller: debounces the two player buttons, sequences IDLE/RUN/DEAD,
// and maintains the BCD score and high score shown by the pixel compositor.
module game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SCORE_DIV       = 10,
  parameter int unsigned DEATH_FRAMES    = 60,
  parameter int unsigned DIGITS          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_btn_l,
  input  logic                  i_btn_r,
  input  logic                  i_frame_tick,
  input  logic                  i_collide,
  output logic [1:0]            o_state,
  output logic                  o_play,
  output logic                  o_freeze,
  output logic                  o_start_pulse,
  output logic [4*DIGITS-1:0]   o_score_bcd,
  output logic [4*DIGITS-1:0]   o_hi_bcd,
  output logic                  o_new_hi
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned FcW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned DcW = $clog2(DEATH_FRAMES + 1);
  localparam int unsigned SW  = 4 * DIGITS;

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FcW-1:0] FcLast = FcW'(SCORE_DIV - 1);
  localparam logic [DcW-1:0] DcMax  = DcW'(DEATH_FRAMES);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDead = 2'b10
  } state_e;

  // Debounce state, bit 0 = left button, bit 1 = right button.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_stable;
  logic [1:0]     r_stable_prev;
  logic [DbW-1:0] r_db_cnt [2];
  logic           w_event;

  state_e         r_state, w_state_d;
  logic [SW-1:0]  r_score, w_score_d;
  logic [SW-1:0]  r_hi, w_hi_d;
  logic           r_new_hi, w_new_hi_d;
  logic [FcW-1:0] r_frame, w_frame_d;
  logic [DcW-1:0] r_dead, w_dead_d;
  logic           r_start, w_start_d;
  logic [SW-1:0]  w_score_inc;

  // Synchronise each button and accept a new level only after DEBOUNCE_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_stable      <= '0;
      r_stable_prev <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1       <= {i_btn_r, i_btn_l};
      r_sync2       <= r_sync1;
      r_stable_prev <= r_stable;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbLast) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // One-cycle event on a rising edge of either stable level; a held button fires once.
  assign w_event = |(r_stable & ~r_stable_prev);

  // BCD increment with per-digit carry; all-nines saturates instead of wrapping.
  always_comb begin
    logic carry;
    logic all_nines;
    w_score_inc = r_score;
    carry       = 1'b1;
    all_nines   = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_score[4*d +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (r_score[4*d +: 4] == 4'd9) begin
          w_score_inc[4*d +: 4] = 4'd0;
        end else begin
          w_score_inc[4*d +: 4] = r_score[4*d +: 4] + 4'd1;
          carry                 = 1'b0;
        end
      end
    end
    if (all_nines) w_score_inc = r_score;
  end

  // Next-state and register updates for the game FSM, score and high score.
  always_comb begin
    w_state_d  = r_state;
    w_score_d  = r_score;
    w_hi_d     = r_hi;
    w_new_hi_d = r_new_hi;
    w_frame_d  = r_frame;
    w_dead_d   = r_dead;
    w_start_d  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_event) begin
          w_state_d = StRun;
          w_score_d = '0;
          w_frame_d = '0;
          w_start_d = 1'b1;
        end
      end
      StRun: begin
        // Collision wins over a coincident frame tick, so the final score is not bumped.
        if (i_collide) begin
          w_state_d = StDead;
          w_dead_d  = '0;
          if (r_score > r_hi) begin
            w_hi_d     = r_score;
            w_new_hi_d = 1'b1;
          end else begin
            w_new_hi_d = 1'b0;
          end
        end else if (i_frame_tick) begin
          if (r_frame == FcLast) begin
            w_frame_d = '0;
            w_score_d = w_score_inc;
          end else begin
            w_frame_d = r_frame + 1'b1;
          end
        end
      end
      StDead: begin
        if (i_frame_tick && (r_dead != DcMax)) w_dead_d = r_dead + 1'b1;
        // Early presses are dropped, not remembered.
        if (w_event && (r_dead == DcMax)) begin
          w_state_d = StRun;
          w_score_d = '0;
          w_frame_d = '0;
          w_start_d = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Game state registers; reset overrides every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_score  <= '0;
      r_hi     <= '0;
      r_new_hi <= 1'b0;
      r_frame  <= '0;
      r_dead   <= '0;
      r_start  <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_score  <= w_score_d;
      r_hi     <= w_hi_d;
      r_new_hi <= w_new_hi_d;
      r_frame  <= w_frame_d;
      r_dead   <= w_dead_d;
      r_start  <= w_start_d;
    end
  end

  assign o_state       = r_state;
  assign o_play        = (r_state == StRun);
  assign o_freeze      = (r_state != StRun);
  assign o_start_pulse = r_start;
  assign o_score_bcd   = r_score;
  assign o_hi_bcd      = r_hi;
  assign o_new_hi      = r_new_hi;

endmodule
